// File: rtl/fp_issue_wb_ctrl.sv
// FP issue/writeback controller: issues add/mult instructions to the FP coprocessor,
// owns the FP register file and writes the coprocessor result back two cycles after accept.
`timescale 1ns/1ps
module fp_issue_wb_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned STATUS_BIT = 8,
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid_i,
    output logic                  inst_ready_o,
    input  logic                  inst_op_i,
    input  logic [REG_ADDR_W-1:0] inst_rs_i,
    input  logic [REG_ADDR_W-1:0] inst_rt_i,
    input  logic [REG_ADDR_W-1:0] inst_rd_i,
    input  logic [2:0]            inst_rnd_i,
    input  logic                  load_en_i,
    input  logic [REG_ADDR_W-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [DATA_WIDTH-1:0] cop_input1_o,
    output logic [DATA_WIDTH-1:0] cop_input2_o,
    output logic                  cop_op_o,
    output logic [2:0]            cop_rnd_o,
    input  logic [DATA_WIDTH-1:0] cop_data_i,
    input  logic [STATUS_BIT-1:0] cop_status_i,
    output logic                  done_o,
    output logic                  busy_o,
    input  logic                  clr_status_i,
    output logic [STATUS_BIT-1:0] status_sticky_o
);

    localparam int unsigned NumRegs = 1 << REG_ADDR_W;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWb    = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] rf_q [NumRegs];
    logic [DATA_WIDTH-1:0] rf_d [NumRegs];
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic                  op_q, op_d;
    logic [2:0]            rnd_q, rnd_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [STATUS_BIT-1:0] sticky_q, sticky_d;

    logic accept;
    logic in_wb;

    assign accept = (state_q == StIdle) && inst_valid_i;
    assign in_wb  = (state_q == StWb);

    // Next-state logic for the issue FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (inst_valid_i) state_d = StIssue;
            StIssue: state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand snapshot on accept; a same-cycle load to rs/rt is forwarded into the snapshot.
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        op_d   = op_q;
        rnd_d  = rnd_q;
        rd_d   = rd_q;
        if (accept) begin
            op_a_d = (load_en_i && (load_addr_i == inst_rs_i)) ? load_data_i : rf_q[inst_rs_i];
            op_b_d = (load_en_i && (load_addr_i == inst_rt_i)) ? load_data_i : rf_q[inst_rt_i];
            op_d   = inst_op_i;
            rnd_d  = inst_rnd_i;
            rd_d   = inst_rd_i;
        end
    end

    // Register file update: loads always proceed, but a writeback to the same address wins
    // because it is applied last.
    always_comb begin
        rf_d = rf_q;
        if (load_en_i) begin
            rf_d[load_addr_i] = load_data_i;
        end
        if (in_wb) begin
            rf_d[rd_q] = cop_data_i;
        end
    end

    // Sticky status: clear first, then OR in the writeback status.
    always_comb begin
        sticky_d = clr_status_i ? '0 : sticky_q;
        if (in_wb) begin
            sticky_d = sticky_d | cop_status_i;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_q     <= 1'b0;
            rnd_q    <= '0;
            rd_q     <= '0;
            sticky_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_q     <= op_d;
            rnd_q    <= rnd_d;
            rd_q     <= rd_d;
            sticky_q <= sticky_d;
            rf_q     <= rf_d;
        end
    end

    assign inst_ready_o    = (state_q == StIdle);
    assign busy_o          = (state_q != StIdle);
    // Suppress the pulse if reset lands on the writeback cycle: that instruction is aborted.
    assign done_o          = in_wb && !rst;
    assign rd_data_o       = rf_q[rd_addr_i];
    assign cop_input1_o    = op_a_q;
    assign cop_input2_o    = op_b_q;
    assign cop_op_o        = op_q;
    assign cop_rnd_o       = rnd_q;
    assign status_sticky_o = sticky_q;

endmodule

// File: tb/tb_fp_issue_wb_ctrl.sv
// Self-checking bench for fp_issue_wb_ctrl: directed scenarios plus randomized instructions
// against a transaction-level model of the register file and sticky status.
`timescale 1ns/1ps
module tb_fp_issue_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic        inst_op_i;
    logic [2:0]  inst_rs_i, inst_rt_i, inst_rd_i, inst_rnd_i;
    logic        load_en_i;
    logic [2:0]  load_addr_i;
    logic [15:0] load_data_i;
    logic [2:0]  rd_addr_i;
    logic [15:0] rd_data_o;
    logic [15:0] cop_input1_o, cop_input2_o;
    logic        cop_op_o;
    logic [2:0]  cop_rnd_o;
    logic [15:0] cop_data_i;
    logic [7:0]  cop_status_i;
    logic        done_o, busy_o, clr_status_i;
    logic [7:0]  status_sticky_o;

    fp_issue_wb_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .inst_valid_i    (inst_valid_i),
        .inst_ready_o    (inst_ready_o),
        .inst_op_i       (inst_op_i),
        .inst_rs_i       (inst_rs_i),
        .inst_rt_i       (inst_rt_i),
        .inst_rd_i       (inst_rd_i),
        .inst_rnd_i      (inst_rnd_i),
        .load_en_i       (load_en_i),
        .load_addr_i     (load_addr_i),
        .load_data_i     (load_data_i),
        .rd_addr_i       (rd_addr_i),
        .rd_data_o       (rd_data_o),
        .cop_input1_o    (cop_input1_o),
        .cop_input2_o    (cop_input2_o),
        .cop_op_o        (cop_op_o),
        .cop_rnd_o       (cop_rnd_o),
        .cop_data_i      (cop_data_i),
        .cop_status_i    (cop_status_i),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .clr_status_i    (clr_status_i),
        .status_sticky_o (status_sticky_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural register contents and sticky status.
    logic [15:0] m_rf [8];
    logic [7:0]  m_sticky;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_valid_i = 1'b0;
        inst_op_i    = 1'b0;
        inst_rs_i    = '0;
        inst_rt_i    = '0;
        inst_rd_i    = '0;
        inst_rnd_i   = '0;
        load_en_i    = 1'b0;
        load_addr_i  = '0;
        load_data_i  = '0;
        cop_data_i   = '0;
        cop_status_i = '0;
        clr_status_i = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        rd_addr_i = addr;
        #1;
        chk(tag, {16'h0, rd_data_o}, {16'h0, exp});
    endtask

    task automatic check_rf_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk_rd(tag, 3'(i), m_rf[i]);
        end
    endtask

    task automatic do_load(input logic [2:0] addr, input logic [15:0] data);
        load_en_i   = 1'b1;
        load_addr_i = addr;
        load_data_i = data;
        tick();
        load_en_i   = 1'b0;
        m_rf[addr]  = data;
    endtask

    // One complete instruction: accept, issue, writeback, back in idle.
    task automatic run_inst(
        input logic        op,
        input logic [2:0]  rs, rt, rd, rnd,
        input logic        f_en, input logic [2:0] f_addr, input logic [15:0] f_data,
        input logic [15:0] cdata, input logic [7:0] cstat,
        input logic        w_en, input logic [2:0] w_addr, input logic [15:0] w_data,
        input logic        w_clr
    );
        logic [15:0] exp_a, exp_b;
        chk("ready_idle", {31'h0, inst_ready_o}, 32'h1);
        exp_a = (f_en && f_addr == rs) ? f_data : m_rf[rs];
        exp_b = (f_en && f_addr == rt) ? f_data : m_rf[rt];
        if (f_en) m_rf[f_addr] = f_data;
        inst_valid_i = 1'b1;
        inst_op_i    = op;
        inst_rs_i    = rs;
        inst_rt_i    = rt;
        inst_rd_i    = rd;
        inst_rnd_i   = rnd;
        load_en_i    = f_en;
        load_addr_i  = f_addr;
        load_data_i  = f_data;
        tick();
        idle_inputs();
        #1;
        chk("issue_busy", {31'h0, busy_o}, 32'h1);
        chk("issue_ready", {31'h0, inst_ready_o}, 32'h0);
        chk("issue_done", {31'h0, done_o}, 32'h0);
        chk("cop_in1", {16'h0, cop_input1_o}, {16'h0, exp_a});
        chk("cop_in2", {16'h0, cop_input2_o}, {16'h0, exp_b});
        chk("cop_op", {31'h0, cop_op_o}, {31'h0, op});
        chk("cop_rnd", {29'h0, cop_rnd_o}, {29'h0, rnd});
        tick();
        cop_data_i   = cdata;
        cop_status_i = cstat;
        load_en_i    = w_en;
        load_addr_i  = w_addr;
        load_data_i  = w_data;
        clr_status_i = w_clr;
        #1;
        chk("wb_done", {31'h0, done_o}, 32'h1);
        chk("wb_ready", {31'h0, inst_ready_o}, 32'h0);
        if (w_en && w_addr != rd) m_rf[w_addr] = w_data;
        m_rf[rd] = cdata;
        m_sticky = (w_clr ? 8'h00 : m_sticky) | cstat;
        tick();
        idle_inputs();
        #1;
        chk("post_done", {31'h0, done_o}, 32'h0);
        chk("post_ready", {31'h0, inst_ready_o}, 32'h1);
        chk("post_sticky", {24'h0, status_sticky_o}, {24'h0, m_sticky});
        chk_rd("post_rd", rd, m_rf[rd]);
    endtask

    initial begin
        logic [6:0]  exp_rdy;
        logic [6:0]  exp_done;
        logic [2:0]  rs, rt, rd, rnd, fa, wa, a;
        logic [15:0] ra, rb;
        logic        fe, we, wc, op;

        idle_inputs();
        rd_addr_i = '0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_sticky = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'h0, inst_ready_o}, 32'h1);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_done", {31'h0, done_o}, 32'h0);
        chk("rst_sticky", {24'h0, status_sticky_o}, 32'h0);
        check_rf_all("rst_rf");

        // Reset asserted for two cycles starting in ISSUE aborts the instruction.
        do_load(3'd1, 16'h1111);
        inst_valid_i = 1'b1;
        inst_rs_i = 3'd1;
        inst_rt_i = 3'd1;
        inst_rd_i = 3'd2;
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("midrst_busy_before", {31'h0, busy_o}, 32'h1);
        chk("midrst_done0", {31'h0, done_o}, 32'h0);
        tick();
        chk("midrst_done1", {31'h0, done_o}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_done2", {31'h0, done_o}, 32'h0);
        chk("midrst_ready", {31'h0, inst_ready_o}, 32'h1);
        chk("midrst_busy", {31'h0, busy_o}, 32'h0);
        chk("midrst_sticky", {24'h0, status_sticky_o}, 32'h0);
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        check_rf_all("midrst_rf");
        tick();
        chk("midrst_done3", {31'h0, done_o}, 32'h0);

        // Add.
        do_load(3'd1, 16'h3C00);
        do_load(3'd2, 16'h4000);
        run_inst(1'b0, 3'd1, 3'd2, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 16'h4200, 8'h00,
                 1'b0, 3'd0, 16'h0, 1'b0);
        chk_rd("add_r3", 3'd3, 16'h4200);

        // Back-to-back mults with valid held high.
        exp_rdy  = 7'b1001001;
        exp_done = 7'b0100100;
        inst_valid_i = 1'b1;
        inst_op_i = 1'b1;
        inst_rs_i = 3'd1;
        inst_rt_i = 3'd2;
        inst_rd_i = 3'd6;
        inst_rnd_i = 3'd2;
        #1;
        chk("b2b_rdy0", {31'h0, inst_ready_o}, {31'h0, exp_rdy[0]});
        chk("b2b_done0", {31'h0, done_o}, {31'h0, exp_done[0]});
        for (int k = 1; k < 7; k++) begin
            tick();
            if (k == 1) begin
                inst_rs_i = 3'd2;
                inst_rt_i = 3'd1;
                inst_rd_i = 3'd7;
                inst_rnd_i = 3'd5;
            end
            if (k == 2) cop_data_i = 16'h4600;
            if (k == 3) cop_data_i = 16'h0;
            if (k == 4) begin
                inst_valid_i = 1'b0;
                chk("b2b_second_in1", {16'h0, cop_input1_o}, 32'h4000);
                chk("b2b_second_rnd", {29'h0, cop_rnd_o}, 32'h5);
            end
            if (k == 5) cop_data_i = 16'h4700;
            if (k == 6) cop_data_i = 16'h0;
            #1;
            chk($sformatf("b2b_rdy%0d", k), {31'h0, inst_ready_o}, {31'h0, exp_rdy[k]});
            chk($sformatf("b2b_done%0d", k), {31'h0, done_o}, {31'h0, exp_done[k]});
        end
        idle_inputs();
        m_rf[6] = 16'h4600;
        m_rf[7] = 16'h4700;
        chk_rd("b2b_r6", 3'd6, 16'h4600);
        chk_rd("b2b_r7", 3'd7, 16'h4700);

        // Forwarding of a same-cycle load into both operands.
        run_inst(1'b0, 3'd1, 3'd1, 3'd4, 3'd1, 1'b1, 3'd1, 16'h4400, 16'h4800, 8'h00,
                 1'b0, 3'd0, 16'h0, 1'b0);
        chk_rd("fwd_r1", 3'd1, 16'h4400);

        // Sticky accumulation and clear-with-writeback.
        clr_status_i = 1'b1;
        tick();
        clr_status_i = 1'b0;
        m_sticky = 8'h00;
        #1;
        chk("clr_sticky", {24'h0, status_sticky_o}, 32'h0);
        run_inst(1'b1, 3'd2, 3'd3, 3'd5, 3'd0, 1'b0, 3'd0, 16'h0, 16'h1000, 8'h04,
                 1'b0, 3'd0, 16'h0, 1'b0);
        run_inst(1'b0, 3'd2, 3'd3, 3'd5, 3'd0, 1'b0, 3'd0, 16'h0, 16'h2000, 8'h10,
                 1'b0, 3'd0, 16'h0, 1'b0);
        chk("sticky_14", {24'h0, status_sticky_o}, 32'h14);
        run_inst(1'b0, 3'd2, 3'd3, 3'd5, 3'd0, 1'b0, 3'd0, 16'h0, 16'h3000, 8'h20,
                 1'b0, 3'd0, 16'h0, 1'b1);
        chk("sticky_clr_wb", {24'h0, status_sticky_o}, 32'h20);

        // Load colliding with writeback, then a load to another address during writeback.
        run_inst(1'b0, 3'd1, 3'd2, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 16'h4200, 8'h00,
                 1'b1, 3'd3, 16'h1234, 1'b0);
        chk_rd("coll_r3", 3'd3, 16'h4200);
        run_inst(1'b0, 3'd1, 3'd2, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 16'h4200, 8'h00,
                 1'b1, 3'd5, 16'h1234, 1'b0);
        chk_rd("coll_r5", 3'd5, 16'h1234);
        chk_rd("coll_r3b", 3'd3, 16'h4200);

        // Randomized instructions with loads and clears sprinkled around them.
        for (int n = 0; n < 40; n++) begin
            op  = 1'($urandom_range(0, 1));
            rs  = 3'($urandom_range(0, 7));
            rt  = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            rnd = 3'($urandom_range(0, 7));
            fe  = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0:       fa = rs;
                1:       fa = rt;
                default: fa = 3'($urandom_range(0, 7));
            endcase
            we  = ($urandom_range(0, 1) == 1);
            wa  = ($urandom_range(0, 1) == 1) ? rd : 3'($urandom_range(0, 7));
            wc  = ($urandom_range(0, 3) == 0);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            run_inst(op, rs, rt, rd, rnd, fe, fa, ra, 16'($urandom), 8'($urandom_range(0, 255)),
                     we, wa, rb, wc);
            if ($urandom_range(0, 2) == 0) begin
                a = 3'($urandom_range(0, 7));
                load_en_i    = 1'b1;
                load_addr_i  = a;
                load_data_i  = ra ^ rb;
                clr_status_i = ($urandom_range(0, 1) == 1);
                m_rf[a] = ra ^ rb;
                if (clr_status_i) m_sticky = 8'h00;
                tick();
                idle_inputs();
                #1;
                chk("rnd_idle_sticky", {24'h0, status_sticky_o}, {24'h0, m_sticky});
                chk_rd("rnd_idle_rd", a, m_rf[a]);
            end
        end
        check_rf_all("final_rf");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
